// File: rtl/nv_nvdla_cdma_wt_req_client.sv
// Weight-read request client: buffers upstream requests in a small FIFO and
// raises a credit-gated request toward the strict-priority arbiter.
module nv_nvdla_cdma_wt_req_client #(
  parameter int DEPTH  = 4,
  parameter int AW     = 64,
  parameter int SW     = 15,
  parameter int CREDIT = 8
) (
  input  logic                         nvdla_core_clk,
  input  logic                         nvdla_core_rstn,
  input  logic                         in_req_valid,
  output logic                         in_req_ready,
  input  logic [AW-1:0]                in_req_addr,
  input  logic [SW-1:0]                in_req_size,
  output logic                         arb_req,
  input  logic                         arb_gnt,
  output logic [AW+SW-1:0]             arb_pd,
  input  logic                         rsp_done,
  output logic [$clog2(CREDIT+1)-1:0]  credit_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_cnt,
  output logic                         idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int KW = $clog2(CREDIT+1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [KW-1:0] MAX_CRED  = KW'(CREDIT);

  logic [AW+SW-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_cnt;
  logic [KW-1:0]    r_credit;

  logic w_push;
  logic w_pop;
  logic w_ret;

  assign in_req_ready = (r_cnt != FULL_CNT);
  assign arb_req      = (r_cnt != '0) && (r_credit != '0);
  assign arb_pd       = r_mem[r_rd_ptr];
  assign fifo_cnt     = r_cnt;
  assign credit_cnt   = r_credit;
  assign idle         = (r_cnt == '0) && (r_credit == MAX_CRED);

  assign w_push = in_req_valid && in_req_ready;
  assign w_pop  = arb_req && arb_gnt;
  // A return at full credit only counts when a pop frees a slot the same cycle.
  assign w_ret  = rsp_done && (w_pop || (r_credit != MAX_CRED));

  // Storage is deliberately left out of reset.
  always_ff @(posedge nvdla_core_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_req_size, in_req_addr};
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_credit <= MAX_CRED;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      case ({w_ret, w_pop})
        2'b10:   r_credit <= r_credit + KW'(1);
        2'b01:   r_credit <= r_credit - KW'(1);
        default: r_credit <= r_credit;
      endcase
    end
  end

endmodule
